// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: loads have priority, ALU writebacks are buffered, and a pending-write scoreboard is kept per register.
// Latency: a write selected in cycle N appears on we/wa/wd after the next posedge; busy is registered and follows the scoreboard counters.
// Backpressure: alu_ready=!fifo_full; ld_ready drops on a WAW match or a forced FIFO drain; issue_ready drops when a counter reaches 3.
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   alu_valid/ready/addr/data        ALU writeback request (buffered)
//   ld_valid/ready/addr/data         load writeback request (priority)
//   issue_valid/ready/addr           decode destination reservation
//   we, wa, wd                       registered register-file write port
//   busy                             per-register pending-write flags
//   fifo_full                        ALU buffer full
module reg_wb_arbiter #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_WIDTH-1:0]        alu_addr,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [ADDR_WIDTH-1:0]        ld_addr,
    input  logic [DATA_WIDTH-1:0]        ld_data,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [ADDR_WIDTH-1:0]        issue_addr,
    output logic                         we,
    output logic [ADDR_WIDTH-1:0]        wa,
    output logic [DATA_WIDTH-1:0]        wd,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy,
    output logic                         fifo_full
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    // ALU writeback buffer
    logic [ADDR_WIDTH-1:0] f_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] f_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] f_vld;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      f_cnt;
    logic [SC_W-1:0]       starve_cnt;

    // Scoreboard
    logic [1:0]            sb_cnt [NREGS];
    logic [1:0]            sb_nxt [NREGS];
    logic [NREGS-1:0]      busy_nxt;

    logic                  fifo_empty;
    logic                  forced;
    logic                  ld_hit;
    logic                  sel_ld;
    logic                  pop;
    logic                  bypass;
    logic                  push;
    logic                  issue_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    assign fifo_empty = (f_cnt == '0);
    assign fifo_full  = (f_cnt == CNT_W'(FIFO_DEPTH));
    assign forced     = !fifo_empty && (starve_cnt == SC_W'(STARVE_LIMIT));

    // A load may not overtake a buffered ALU write to the same register.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (f_vld[i] && (f_addr[i] == ld_addr)) begin
                ld_hit = 1'b1;
            end
        end
    end

    assign alu_ready = !fifo_full;
    assign ld_ready  = !forced && !ld_hit;

    assign sel_ld = ld_valid && ld_ready;
    // The head drains whenever the load does not take the port (forced implies !sel_ld).
    assign pop    = !fifo_empty && !sel_ld;
    assign bypass = fifo_empty && alu_valid && !sel_ld;
    assign push   = alu_valid && alu_ready && !bypass;

    always_comb begin
        wr_addr = ld_addr;
        wr_data = ld_data;
        if (pop) begin
            wr_addr = f_addr[rd_ptr];
            wr_data = f_data[rd_ptr];
        end else if (bypass) begin
            wr_addr = alu_addr;
            wr_data = alu_data;
        end
    end

    // Buffer payload needs no reset; validity lives in f_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            f_addr[wr_ptr] <= alu_addr;
            f_data[wr_ptr] <= alu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_vld      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            f_cnt      <= '0;
            starve_cnt <= '0;
        end else begin
            if (pop) begin
                f_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                f_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   f_cnt <= f_cnt + 1'b1;
                2'b01:   f_cnt <= f_cnt - 1'b1;
                default: f_cnt <= f_cnt;
            endcase
            if (fifo_empty || pop) begin
                starve_cnt <= '0;
            end else if (sel_ld && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else begin
            we <= sel_ld || pop || bypass;
            if (sel_ld || pop || bypass) begin
                wa <= wr_addr;
                wd <= wr_data;
            end
        end
    end

    assign issue_ready = (sb_cnt[issue_addr] != 2'd3);
    assign issue_fire  = issue_valid && issue_ready;

    // Reservation and retirement of the same register cancel out.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            sb_nxt[i] = sb_cnt[i];
            if (issue_fire && (issue_addr == ADDR_WIDTH'(i)) && !(we && (wa == ADDR_WIDTH'(i)))) begin
                sb_nxt[i] = sb_cnt[i] + 2'd1;
            end else if (we && (wa == ADDR_WIDTH'(i)) && !(issue_fire && (issue_addr == ADDR_WIDTH'(i)))
                         && (sb_cnt[i] != 2'd0)) begin
                sb_nxt[i] = sb_cnt[i] - 2'd1;
            end
            busy_nxt[i] = (sb_nxt[i] != 2'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                sb_cnt[i] <= 2'd0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                sb_cnt[i] <= sb_nxt[i];
            end
            busy <= busy_nxt;
        end
    end

`ifndef SYNTHESIS
    // A retirement with no outstanding reservation means decode lost track of a write.
    always @(posedge clk) begin
        if (!reset && we && !(issue_fire && (issue_addr == wa))) begin
            assert (sb_cnt[wa] != 2'd0)
                else $error("reg_wb_arbiter: write to r%0d with no pending reservation", wa);
        end
    end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_addr;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [15:0] busy;
    logic        fifo_full;

    int n_checks = 0;
    int n_errors = 0;

    reg_wb_arbiter #(
        .ADDR_WIDTH  (4),
        .DATA_WIDTH  (32),
        .FIFO_DEPTH  (2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_addr (issue_addr),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .busy       (busy),
        .fifo_full  (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
            else begin
                n_errors++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reserve a destination register for one cycle of issue.
    task automatic issue(input logic [3:0] a);
        issue_valid = 1'b1;
        issue_addr  = a;
        step();
        issue_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        alu_valid   = 1'b0;
        alu_addr    = '0;
        alu_data    = '0;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_wa", 64'(wa), 64'd0);
        chk("rst_wd", 64'(wd), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fifo_full", 64'(fifo_full), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        step();

        // ---------------- bypass ----------------
        issue(4'd3);
        chk("byp_busy3_set", 64'(busy[3]), 64'd1);
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h11;
        #1;
        chk("byp_alu_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 1'b0;
        chk("byp_we", 64'(we), 64'd1);
        chk("byp_wa", 64'(wa), 64'd3);
        chk("byp_wd", 64'(wd), 64'h11);
        chk("byp_busy3_held", 64'(busy[3]), 64'd1);
        step();
        chk("byp_we_off", 64'(we), 64'd0);
        chk("byp_busy3_clr", 64'(busy[3]), 64'd0);

        // ---------------- collision ----------------
        issue(4'd5);
        issue(4'd6);
        ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 32'hAA;
        alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 32'hBB;
        #1;
        chk("col_ld_ready", 64'(ld_ready), 64'd1);
        chk("col_alu_ready", 64'(alu_ready), 64'd1);
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        chk("col_wa_ld", 64'(wa), 64'd5);
        chk("col_wd_ld", 64'(wd), 64'hAA);
        chk("col_fifo_full", 64'(fifo_full), 64'd0);
        step();
        chk("col_we_alu", 64'(we), 64'd1);
        chk("col_wa_alu", 64'(wa), 64'd6);
        chk("col_wd_alu", 64'(wd), 64'hBB);
        step();
        chk("col_we_idle", 64'(we), 64'd0);
        chk("col_busy", 64'(busy), 64'd0);

        // ---------------- WAW ----------------
        issue(4'd8);
        issue(4'd7);
        issue(4'd7);
        ld_valid = 1'b1; ld_addr = 4'd8; ld_data = 32'h8;
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'h1;
        step();
        alu_valid = 1'b0;
        ld_addr = 4'd7; ld_data = 32'h2;
        chk("waw_wa_ld8", 64'(wa), 64'd8);
        #1;
        chk("waw_ld_blocked", 64'(ld_ready), 64'd0);
        step();
        chk("waw_wa_first", 64'(wa), 64'd7);
        chk("waw_wd_first", 64'(wd), 64'h1);
        chk("waw_ld_released", 64'(ld_ready), 64'd1);
        step();
        ld_valid = 1'b0;
        chk("waw_we_second", 64'(we), 64'd1);
        chk("waw_wa_second", 64'(wa), 64'd7);
        chk("waw_wd_second", 64'(wd), 64'h2);
        step();
        chk("waw_busy", 64'(busy), 64'd0);

        // ---------------- starvation ----------------
        issue(4'd2);
        for (int r = 10; r <= 15; r++) issue(4'(r));
        ld_valid = 1'b1; ld_addr = 4'd10; ld_data = 32'hA0;
        alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 32'h5;
        step();
        alu_valid = 1'b0;
        chk("stv_wa_first_ld", 64'(wa), 64'd10);
        for (int k = 1; k <= 4; k++) begin
            ld_addr = 4'(10 + k);
            ld_data = 32'(8'hA0 + k);
            #1;
            chk($sformatf("stv_ld_ready_%0d", k), 64'(ld_ready), 64'd1);
            step();
            chk($sformatf("stv_wa_ld_%0d", k), 64'(wa), 64'(10 + k));
        end
        ld_addr = 4'd15; ld_data = 32'hF0;
        #1;
        chk("stv_forced_ld_ready", 64'(ld_ready), 64'd0);
        step();
        chk("stv_forced_wa", 64'(wa), 64'd2);
        chk("stv_forced_wd", 64'(wd), 64'h5);
        chk("stv_after_ld_ready", 64'(ld_ready), 64'd1);
        step();
        ld_valid = 1'b0;
        chk("stv_wa_last", 64'(wa), 64'd15);
        chk("stv_wd_last", 64'(wd), 64'hF0);
        step();
        chk("stv_busy", 64'(busy), 64'd0);

        // ---------------- full / scoreboard ----------------
        issue(4'd9);
        issue(4'd9);
        issue(4'd9);
        issue_valid = 1'b1; issue_addr = 4'd9;
        #1;
        chk("sb_issue_ready_sat", 64'(issue_ready), 64'd0);
        issue_valid = 1'b0;
        chk("sb_busy9", 64'(busy[9]), 64'd1);
        issue(4'd4);
        issue(4'd4);
        ld_valid = 1'b1; ld_addr = 4'd4; ld_data = 32'h41;
        alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 32'h91;
        step();
        ld_data = 32'h42; alu_data = 32'h92;
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        chk("full_fifo_full", 64'(fifo_full), 64'd1);
        chk("full_alu_ready", 64'(alu_ready), 64'd0);
        chk("full_wd_ld", 64'(wd), 64'h42);
        step();
        chk("full_wa_pop1", 64'(wa), 64'd9);
        chk("full_wd_pop1", 64'(wd), 64'h91);
        chk("full_not_full", 64'(fifo_full), 64'd0);
        step();
        chk("full_wd_pop2", 64'(wd), 64'h92);
        step();
        chk("full_we_idle", 64'(we), 64'd0);

        // ---------------- reset mid-run ----------------
        issue(4'd1);
        issue(4'd1);
        ld_valid = 1'b1; ld_addr = 4'd1; ld_data = 32'h1A;
        alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 32'hA1;
        step();
        ld_data = 32'h1B; alu_data = 32'hA2;
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        chk("mid_fifo_full_pre", 64'(fifo_full), 64'd1);
        chk("mid_we_pre", 64'(we), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_we_async", 64'(we), 64'd0);
        chk("mid_busy_async", 64'(busy), 64'd0);
        chk("mid_fifo_full_async", 64'(fifo_full), 64'd0);
        step();
        reset = 1'b0;
        #1;
        chk("mid_alu_ready", 64'(alu_ready), 64'd1);
        chk("mid_ld_ready", 64'(ld_ready), 64'd1);
        step();
        chk("mid_no_stale_1", 64'(we), 64'd0);
        step();
        chk("mid_no_stale_2", 64'(we), 64'd0);
        chk("mid_busy_post", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
